sound_receiver: RTL and testbench

SOUND_RECEIVER -- requirements
Module: sound_receiver

---
 rtl/sound_receiver.sv | 103 ++++++++++
 tb/tb_sound_receiver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sound_receiver.sv
// I2S-style serial audio receiver: synchronizes the codec bit clock, frames
// left/right slots on LRCK changes and presents coherent sample pairs.
module sound_receiver #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             AUD_BCLK,
  input  logic             AUD_LRCK,
  input  logic             AUD_DIN,
  input  logic             enable,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  output logic             short_slot
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]       bclk_sync;
  logic [1:0]       lrck_sync;
  logic [1:0]       din_sync;
  logic             lrck_prev;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] left_hold;
  logic [CW-1:0]    bit_cnt;
  logic             channel;
  logic             synced;
  logic             left_ok;

  logic             bclk_rise;
  logic             lrck;
  logic             din;
  logic             lr_change;
  logic             cnt_full;
  logic [WIDTH-1:0] word_next;

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lrck      = lrck_sync[1];
  assign din       = din_sync[1];
  assign lr_change = lrck != lrck_prev;
  assign cnt_full  = bit_cnt == CW'(WIDTH);
  assign word_next = {shreg[WIDTH-2:0], din};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      din_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_LRCK};
      din_sync  <= {din_sync[0], AUD_DIN};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lrck_prev    <= 1'b0;
      shreg        <= '0;
      left_hold    <= '0;
      bit_cnt      <= '0;
      channel      <= 1'b0;
      synced       <= 1'b0;
      left_ok      <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      short_slot   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      short_slot   <= 1'b0;
      // lrck_prev keeps tracking while disabled so re-enable waits for a real edge
      if (bclk_rise) lrck_prev <= lrck;
      if (!enable) begin
        synced  <= 1'b0;
        left_ok <= 1'b0;
        bit_cnt <= '0;
      end else if (bclk_rise) begin
        if (lr_change) begin
          // DIN on the LRCK edge is the previous slot's last bit: dropped
          short_slot <= synced && !cnt_full;
          bit_cnt    <= '0;
          channel    <= lrck;
          synced     <= 1'b1;
          if (!lrck) left_ok <= 1'b0;
        end else if (synced && !cnt_full) begin
          shreg   <= word_next;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(WIDTH - 1)) begin
            if (!channel) begin
              left_hold <= word_next;
              left_ok   <= 1'b1;
            end else if (left_ok) begin
              left_data    <= left_hold;
              right_data   <= word_next;
              sample_valid <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sound_receiver.sv
// Bench for sound_receiver: serial transmitter model, table-driven frames,
// reset/enable corner sequences and a randomized loopback run.
module tb_sound_receiver;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         AUD_BCLK = 1'b0;
  logic         AUD_LRCK = 1'b0;
  logic         AUD_DIN = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] left_data, right_data;
  logic         sample_valid, short_slot;

  int n_vec = 0;
  int n_bad = 0;
  int vcnt = 0;
  int scnt = 0;
  int bhalf = 8;
  logic [31:0] obs[$];
  logic [W-1:0] last_l = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           llen;
    int           ev;
    int           es;
  } vec_t;
  vec_t tbl[7];

  always #5 CLK = ~CLK;

  sound_receiver #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AUD_BCLK(AUD_BCLK), .AUD_LRCK(AUD_LRCK),
    .AUD_DIN(AUD_DIN), .enable(enable), .left_data(left_data),
    .right_data(right_data), .sample_valid(sample_valid), .short_slot(short_slot)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observer: collects pulses and flags data moving without a valid pulse
  logic [W-1:0] pl = '0, pr = '0;
  logic rprev = 1'b0;
  always @(negedge CLK) begin
    if (RESET_N && rprev && !sample_valid && (left_data !== pl || right_data !== pr)) begin
      n_bad++;
      $display("FAIL data_glitch: got %h/%h expected %h/%h", left_data, right_data, pl, pr);
    end
    if (sample_valid) begin
      vcnt++;
      obs.push_back({left_data, right_data});
    end
    if (short_slot) scnt++;
    pl = left_data;
    pr = right_data;
    rprev = RESET_N;
  end

  // Transmitter: LRCK/DIN change on BCLK fall, MSB one BCLK after the LRCK edge
  task automatic send_slot(input logic lr, input logic [W-1:0] w, input int len);
    for (int k = 0; k < len; k++) begin
      AUD_BCLK = 1'b0;
      AUD_LRCK = lr;
      AUD_DIN  = (k >= 1 && k <= W) ? w[W-k] : 1'($urandom);
      #(bhalf * 10);
      AUD_BCLK = 1'b1;
      #(bhalf * 10);
    end
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int llen);
    send_slot(1'b0, l, llen);
    send_slot(1'b1, r, 24);
  endtask

  task automatic clr();
    vcnt = 0;
    scnt = 0;
    obs.delete();
  endtask

  task automatic check_frame(input string tag, input int ev, input int es,
                             input logic [W-1:0] l, input logic [W-1:0] r);
    logic [31:0] p;
    chk({tag, "_valid_cnt"}, 32'(vcnt), 32'(ev));
    chk({tag, "_short_cnt"}, 32'(scnt), 32'(es));
    if (ev == 1) begin
      last_l = l;
      last_r = r;
      p = (obs.size() > 0) ? obs[0] : 32'hxxxx_xxxx;
      chk({tag, "_pair"}, p, {l, r});
    end
    chk({tag, "_left_data"}, 32'(left_data), 32'(last_l));
    chk({tag, "_right_data"}, 32'(right_data), 32'(last_r));
  endtask

  initial begin
    tbl[0] = '{16'h8001, 16'h7FFE, 24, 1, 0};
    tbl[1] = '{16'h0000, 16'hFFFF, 24, 1, 0};
    tbl[2] = '{16'h1111, 16'h2222, 11, 0, 1};
    tbl[3] = '{16'h1234, 16'hABCD, 24, 1, 0};
    tbl[4] = '{16'hFFFF, 16'h0000, 17, 1, 0};
    tbl[5] = '{16'hAAAA, 16'h5555, 16, 0, 1};
    tbl[6] = '{16'h5A5A, 16'hA5A5, 32, 1, 0};

    #3 enable = 1'b1;
    #20;
    chk("rst_left", 32'(left_data), 32'h0);
    chk("rst_right", 32'(right_data), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_short", 32'(short_slot), 32'h0);
    #20 RESET_N = 1'b1;

    // Right slot first: syncs framing but no left word yet
    clr();
    send_slot(1'b1, 16'($urandom), 24);
    chk("prime_valid_cnt", 32'(vcnt), 32'h0);
    chk("prime_short_cnt", 32'(scnt), 32'h0);

    for (int i = 0; i < 7; i++) begin
      clr();
      frame(tbl[i].l, tbl[i].r, tbl[i].llen);
      check_frame($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].es, tbl[i].l, tbl[i].r);
    end

    // Reset in the middle of a right slot
    clr();
    send_slot(1'b0, 16'h0F0F, 24);
    fork
      send_slot(1'b1, 16'hF0F0, 24);
      begin
        #(bhalf * 20 * 6 + 3);
        RESET_N = 1'b0;
        #1;
        chk("midrst_left", 32'(left_data), 32'h0);
        chk("midrst_right", 32'(right_data), 32'h0);
        chk("midrst_valid", 32'(sample_valid), 32'h0);
        chk("midrst_short", 32'(short_slot), 32'h0);
        #47 RESET_N = 1'b1;
      end
    join
    chk("midrst_valid_cnt", 32'(vcnt), 32'h0);
    last_l = '0;
    last_r = '0;
    clr();
    frame(16'h3333, 16'h4444, 6);
    check_frame("leftless", 0, 1, 16'h0, 16'h0);
    clr();
    frame(16'h1357, 16'h2468, 24);
    check_frame("post_rst", 1, 0, 16'h1357, 16'h2468);

    // Enable low for three frames
    enable = 1'b0;
    clr();
    for (int i = 0; i < 3; i++) frame(16'($urandom), 16'($urandom), 24);
    check_frame("disabled", 0, 0, 16'h0, 16'h0);
    enable = 1'b1;
    clr();
    frame(16'hC0DE, 16'hBEEF, 24);
    check_frame("reenable", 1, 0, 16'hC0DE, 16'hBEEF);

    // Randomized loopback at the fastest allowed bit clock
    bhalf = 4;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] l, r;
      l = 16'($urandom);
      r = 16'($urandom);
      clr();
      frame(l, r, 24);
      check_frame("rand", 1, 0, l, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
